// File: rtl/spi_pwm_channel_bank_if.sv
// spi_pwm_channel_bank_if: received-byte stream and chip select feeding the PWM channel bank.
interface spi_pwm_channel_bank_if;
   logic [7:0] rx_byte;
   logic       rx_rdy;
   logic       cs_n;
   modport master (output rx_byte, rx_rdy, cs_n);
   modport slave  (input  rx_byte, rx_rdy, cs_n);
endinterface

// File: rtl/spi_pwm_channel_bank.sv
// spi_pwm_channel_bank: loads NUM_CH PWM duties from 0xA5-headed SPI frames, applied only at counter wrap.
// Define SPI_PWM_CHECKSUM_EN to require a trailing modulo-256 checksum byte per frame.
module spi_pwm_channel_bank #(
   parameter int NUM_CH = 4,
   parameter int DUTY_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   spi_pwm_channel_bank_if.slave spi,
   output logic [NUM_CH-1:0]     pwm_out,
   output logic                  frame_ok,
   output logic                  frame_err,
   output logic                  busy
);
   localparam int BPC = (DUTY_W + 7) / 8;
   localparam int NB  = NUM_CH * BPC;
   localparam int BCW = NB > 1 ? $clog2(NB) : 1;
   localparam logic [BCW-1:0] LAST = BCW'(NB - 1);
`ifdef SPI_PWM_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, DATA, CSUM, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, DATA, DONE} state_t;
`endif
   state_t            st;
   logic [BCW-1:0]    bc;
   logic [7:0]        stg  [NB];
   logic [DUTY_W-1:0] pend [NUM_CH];
   logic [DUTY_W-1:0] act  [NUM_CH];
   logic [DUTY_W-1:0] sdut [NUM_CH];
   logic [DUTY_W-1:0] cnt;
   logic              pend_v;
   logic              wrap;
   logic              csum_bad;
   logic              drop;
`ifdef SPI_PWM_CHECKSUM_EN
   logic [7:0]        sum;
   assign csum_bad = st == CSUM && spi.rx_rdy && spi.rx_byte != sum;
`else
   assign csum_bad = 1'b0;
`endif
   assign wrap = &cnt;
   assign busy = st != IDLE;
   // cs_n high mid-frame wins over a same-cycle byte
   assign drop = (st != IDLE && st != DONE && spi.cs_n) || csum_bad;
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [8*BPC-1:0] w;
      for (genvar b = 0; b < BPC; b++) begin : g_b
         assign w[8*(BPC-1-b) +: 8] = stg[c*BPC+b];
      end
      assign sdut[c] = w[DUTY_W-1:0];
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         st        <= IDLE;
         bc        <= '0;
         pend_v    <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         for (int i = 0; i < NB; i++) stg[i] <= '0;
         for (int i = 0; i < NUM_CH; i++) pend[i] <= '0;
`ifdef SPI_PWM_CHECKSUM_EN
         sum       <= '0;
`endif
      end else begin
         frame_ok  <= 1'b0;
         frame_err <= drop;
         if (wrap) pend_v <= 1'b0;
         if (drop) begin
            st <= IDLE;
            for (int i = 0; i < NB; i++) stg[i] <= '0;
         end else begin
            case (st)
               IDLE: if (spi.rx_rdy && spi.rx_byte == 8'hA5) begin
                  st <= DATA;
                  bc <= '0;
`ifdef SPI_PWM_CHECKSUM_EN
                  sum <= '0;
`endif
               end
               DATA: if (spi.rx_rdy) begin
                  stg[bc] <= spi.rx_byte;
                  bc      <= bc + 1'b1;
`ifdef SPI_PWM_CHECKSUM_EN
                  sum     <= sum + spi.rx_byte;
                  if (bc == LAST) st <= CSUM;
`else
                  if (bc == LAST) st <= DONE;
`endif
               end
`ifdef SPI_PWM_CHECKSUM_EN
               CSUM: if (spi.rx_rdy) st <= DONE;
`endif
               DONE: begin
                  // a DONE on the wrap cycle re-arms pend_v, deferring to the next wrap
                  for (int i = 0; i < NUM_CH; i++) pend[i] <= sdut[i];
                  pend_v   <= 1'b1;
                  frame_ok <= 1'b1;
                  st       <= IDLE;
               end
               default: st <= IDLE;
            endcase
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         pwm_out <= '0;
         for (int i = 0; i < NUM_CH; i++) act[i] <= '0;
      end else begin
         cnt <= cnt + 1'b1;
         for (int i = 0; i < NUM_CH; i++) begin
            pwm_out[i] <= cnt < act[i];
            if (wrap && pend_v) act[i] <= pend[i];
         end
      end
   end
endmodule

// File: tb/tb_spi_pwm_channel_bank.sv
// tb_spi_pwm_channel_bank: scoreboard bench for a default 4x8 bank and a 2x12 bank.
`timescale 1ns/1ps
module tb_spi_pwm_channel_bank;
   logic clk = 1'b0;
   logic r1, r2;
   always #5 clk = ~clk;
   spi_pwm_channel_bank_if s1 ();
   spi_pwm_channel_bank_if s2 ();
   logic [3:0] p1;
   logic [1:0] p2;
   logic ok1, er1, by1, ok2, er2, by2;
   spi_pwm_channel_bank dut1 (.clk(clk), .reset(r1), .spi(s1), .pwm_out(p1),
                              .frame_ok(ok1), .frame_err(er1), .busy(by1));
   spi_pwm_channel_bank #(.NUM_CH(2), .DUTY_W(12)) dut2 (.clk(clk), .reset(r2), .spi(s2), .pwm_out(p2),
                              .frame_ok(ok2), .frame_err(er2), .busy(by2));
   int checks = 0;
   int failures = 0;
   logic [1:0] exp1[$], exp2[$], obs1[$], obs2[$];
   int o1 = 0;
   int o2 = 0;
   logic [7:0] tcnt;
`ifdef SPI_PWM_CHECKSUM_EN
   localparam int FB = 6;
`else
   localparam int FB = 5;
`endif
   always @(posedge clk) tcnt <= r1 ? 8'd0 : tcnt + 8'd1;
   always @(negedge clk) begin
      if (ok1 || er1) obs1.push_back({er1, ok1});
      if (ok2 || er2) obs2.push_back({er2, ok2});
   end
   task automatic send(input bit sel, input logic [7:0] b);
      if (sel) begin s2.rx_byte = b; s2.rx_rdy = 1'b1; end
      else begin s1.rx_byte = b; s1.rx_rdy = 1'b1; end
      @(negedge clk);
      s1.rx_rdy = 1'b0;
      s2.rx_rdy = 1'b0;
      @(negedge clk);
   endtask
   task automatic frame(input bit sel, input logic [7:0] a, b, c, d);
      if (sel) s2.cs_n = 1'b0; else s1.cs_n = 1'b0;
      send(sel, 8'hA5);
      send(sel, a);
      send(sel, b);
      send(sel, c);
      send(sel, d);
`ifdef SPI_PWM_CHECKSUM_EN
      send(sel, a + b + c + d);
`endif
      s1.cs_n = 1'b1;
      s2.cs_n = 1'b1;
   endtask
   task automatic measure(input bit align, output int c [4]);
      for (int i = 0; i < 4; i++) c[i] = 0;
      for (int i = 0; i < 300 && align && tcnt != 8'd1; i++) @(negedge clk);
      for (int k = 0; k < 256; k++) begin
         for (int i = 0; i < 4; i++) c[i] += int'(p1[i]);
         @(negedge clk);
      end
   endtask
   task automatic test_reset;
      r1 = 1'b1; r2 = 1'b1;
      s1.rx_byte = 8'h00; s1.rx_rdy = 1'b0; s1.cs_n = 1'b1;
      s2.rx_byte = 8'h00; s2.rx_rdy = 1'b0; s2.cs_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (p1 !== 4'b0) begin failures++; $display("FAIL reset_pwm1 got=%b want=0000", p1); end
      checks++;
      if ({ok1, er1, by1} !== 3'b0) begin failures++; $display("FAIL reset_flags1 got=%b want=000", {ok1, er1, by1}); end
      checks++;
      if (p2 !== 2'b0) begin failures++; $display("FAIL reset_pwm2 got=%b want=00", p2); end
      checks++;
      if ({ok2, er2, by2} !== 3'b0) begin failures++; $display("FAIL reset_flags2 got=%b want=000", {ok2, er2, by2}); end
      r1 = 1'b0; r2 = 1'b0;
      @(negedge clk);
   endtask
   task automatic test_frame;
      int c [4];
      logic [1:0] e, g;
      exp1.push_back(2'b01);
      frame(0, 8'h10, 8'h20, 8'h30, 8'h40);
      repeat (10) @(negedge clk);
      checks++;
      if (obs1.size() - o1 != exp1.size()) begin failures++; $display("FAIL frame_events got=%0d want=%0d", obs1.size() - o1, exp1.size()); end
      while (exp1.size() > 0) begin
         e = exp1.pop_front(); g = o1 < obs1.size() ? obs1[o1] : 2'b00; o1++;
         checks++;
         if (g !== e) begin failures++; $display("FAIL frame_event got=%b want=%b", g, e); end
      end
      o1 = obs1.size();
      checks++;
      if (by1 !== 1'b0) begin failures++; $display("FAIL frame_busy got=%b want=0", by1); end
      repeat (300) @(negedge clk);
      measure(1, c);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (c[i] != 16 * (i + 1)) begin failures++; $display("FAIL frame_duty ch%0d got=%0d want=%0d", i, c[i], 16 * (i + 1)); end
      end
   endtask
   task automatic test_ignore;
      int c [4];
      logic [1:0] e, g;
      logic [7:0] want [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
      s1.cs_n = 1'b0;
      send(0, 8'h00);
      send(0, 8'hFF);
      exp1.push_back(2'b01);
      frame(0, 8'h44, 8'h33, 8'h22, 8'h11);
      repeat (10) @(negedge clk);
      checks++;
      if (obs1.size() - o1 != exp1.size()) begin failures++; $display("FAIL ignore_events got=%0d want=%0d", obs1.size() - o1, exp1.size()); end
      while (exp1.size() > 0) begin
         e = exp1.pop_front(); g = o1 < obs1.size() ? obs1[o1] : 2'b00; o1++;
         checks++;
         if (g !== e) begin failures++; $display("FAIL ignore_event got=%b want=%b", g, e); end
      end
      o1 = obs1.size();
      repeat (300) @(negedge clk);
      measure(0, c);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (c[i] != int'(want[i])) begin failures++; $display("FAIL ignore_duty ch%0d got=%0d want=%0d", i, c[i], want[i]); end
      end
   endtask
   task automatic test_abort;
      int c [4];
      logic [1:0] e, g;
      logic [7:0] want [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
      s1.cs_n = 1'b0;
      send(0, 8'hA5);
      send(0, 8'h80);
      send(0, 8'h80);
      checks++;
      if (by1 !== 1'b1) begin failures++; $display("FAIL abort_busy_mid got=%b want=1", by1); end
      exp1.push_back(2'b10);
      s1.cs_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (by1 !== 1'b0) begin failures++; $display("FAIL abort_busy_after got=%b want=0", by1); end
      s1.cs_n = 1'b0;
      send(0, 8'hA5);
      send(0, 8'h01);
      send(0, 8'h02);
      send(0, 8'h03);
      exp1.push_back(2'b10);
      s1.rx_byte = 8'h04; s1.rx_rdy = 1'b1; s1.cs_n = 1'b1;
      @(negedge clk);
      s1.rx_rdy = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (obs1.size() - o1 != exp1.size()) begin failures++; $display("FAIL abort_events got=%0d want=%0d", obs1.size() - o1, exp1.size()); end
      while (exp1.size() > 0) begin
         e = exp1.pop_front(); g = o1 < obs1.size() ? obs1[o1] : 2'b00; o1++;
         checks++;
         if (g !== e) begin failures++; $display("FAIL abort_event got=%b want=%b", g, e); end
      end
      o1 = obs1.size();
      repeat (300) @(negedge clk);
      measure(0, c);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (c[i] != int'(want[i])) begin failures++; $display("FAIL abort_duty ch%0d got=%0d want=%0d", i, c[i], want[i]); end
      end
   endtask
   task automatic test_back_to_back;
      int c [4];
      logic [1:0] e, g;
      for (int i = 0; i < 300 && tcnt != 8'd1; i++) @(negedge clk);
      exp1.push_back(2'b01);
      frame(0, 8'h20, 8'h20, 8'h20, 8'h20);
      @(negedge clk);
      exp1.push_back(2'b01);
      frame(0, 8'h60, 8'h60, 8'h60, 8'h60);
      repeat (10) @(negedge clk);
      checks++;
      if (obs1.size() - o1 != exp1.size()) begin failures++; $display("FAIL b2b_events got=%0d want=%0d", obs1.size() - o1, exp1.size()); end
      while (exp1.size() > 0) begin
         e = exp1.pop_front(); g = o1 < obs1.size() ? obs1[o1] : 2'b00; o1++;
         checks++;
         if (g !== e) begin failures++; $display("FAIL b2b_event got=%b want=%b", g, e); end
      end
      o1 = obs1.size();
      for (int p = 0; p < 2; p++) begin
         measure(1, c);
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (c[i] != 8'h60) begin failures++; $display("FAIL b2b_duty period%0d ch%0d got=%0d want=96", p, i, c[i]); end
         end
      end
   endtask
   task automatic test_wrap_done;
      int c [4];
      logic [1:0] e, g;
      for (int i = 0; i < 300 && tcnt != 8'(254 - 2 * (FB - 1)); i++) @(negedge clk);
      exp1.push_back(2'b01);
      frame(0, 8'h08, 8'h08, 8'h08, 8'h08);
      for (int p = 0; p < 2; p++) begin
         measure(1, c);
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (c[i] != (p == 0 ? 8'h60 : 8'h08)) begin failures++; $display("FAIL wrap_done_duty period%0d ch%0d got=%0d want=%0d", p, i, c[i], p == 0 ? 96 : 8); end
         end
      end
      checks++;
      if (obs1.size() - o1 != exp1.size()) begin failures++; $display("FAIL wrap_done_events got=%0d want=%0d", obs1.size() - o1, exp1.size()); end
      while (exp1.size() > 0) begin
         e = exp1.pop_front(); g = o1 < obs1.size() ? obs1[o1] : 2'b00; o1++;
         checks++;
         if (g !== e) begin failures++; $display("FAIL wrap_done_event got=%b want=%b", g, e); end
      end
      o1 = obs1.size();
   endtask
`ifdef SPI_PWM_CHECKSUM_EN
   task automatic test_checksum;
      int c [4];
      logic [1:0] e, g;
      exp1.push_back(2'b01);
      frame(0, 8'h01, 8'h02, 8'h03, 8'h04);
      s1.cs_n = 1'b0;
      send(0, 8'hA5);
      send(0, 8'h01);
      send(0, 8'h02);
      send(0, 8'h03);
      send(0, 8'h04);
      exp1.push_back(2'b10);
      send(0, 8'h0B);
      s1.cs_n = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (obs1.size() - o1 != exp1.size()) begin failures++; $display("FAIL csum_events got=%0d want=%0d", obs1.size() - o1, exp1.size()); end
      while (exp1.size() > 0) begin
         e = exp1.pop_front(); g = o1 < obs1.size() ? obs1[o1] : 2'b00; o1++;
         checks++;
         if (g !== e) begin failures++; $display("FAIL csum_event got=%b want=%b", g, e); end
      end
      o1 = obs1.size();
      repeat (300) @(negedge clk);
      measure(0, c);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (c[i] != i + 1) begin failures++; $display("FAIL csum_duty ch%0d got=%0d want=%0d", i, c[i], i + 1); end
      end
   endtask
`endif
   task automatic test_wide;
      int h0, h1;
      logic [1:0] e, g;
      exp2.push_back(2'b01);
      frame(1, 8'h0F, 8'hFF, 8'h08, 8'h00);
      repeat (10) @(negedge clk);
      checks++;
      if (obs2.size() - o2 != exp2.size()) begin failures++; $display("FAIL wide_events got=%0d want=%0d", obs2.size() - o2, exp2.size()); end
      while (exp2.size() > 0) begin
         e = exp2.pop_front(); g = o2 < obs2.size() ? obs2[o2] : 2'b00; o2++;
         checks++;
         if (g !== e) begin failures++; $display("FAIL wide_event got=%b want=%b", g, e); end
      end
      o2 = obs2.size();
      repeat (4200) @(negedge clk);
      h0 = 0; h1 = 0;
      for (int k = 0; k < 4096; k++) begin
         h0 += int'(p2[0]);
         h1 += int'(p2[1]);
         @(negedge clk);
      end
      checks++;
      if (h0 != 4095) begin failures++; $display("FAIL wide_duty ch0 got=%0d want=4095", h0); end
      checks++;
      if (h1 != 2048) begin failures++; $display("FAIL wide_duty ch1 got=%0d want=2048", h1); end
      s2.cs_n = 1'b0;
      send(1, 8'hA5);
      send(1, 8'h0F);
      checks++;
      if (by2 !== 1'b1) begin failures++; $display("FAIL wide_busy_mid got=%b want=1", by2); end
      r2 = 1'b1;
      @(negedge clk);
      checks++;
      if ({p2, ok2, er2, by2} !== 5'b0) begin failures++; $display("FAIL wide_reset_outputs got=%b want=00000", {p2, ok2, er2, by2}); end
      r2 = 1'b0;
      s2.cs_n = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (obs2.size() != o2) begin failures++; $display("FAIL wide_reset_events got=%0d want=0", obs2.size() - o2); end
   endtask
   initial begin
      test_reset;
      test_frame;
      test_ignore;
      test_abort;
      test_back_to_back;
      test_wrap_done;
`ifdef SPI_PWM_CHECKSUM_EN
      test_checksum;
`endif
      test_wide;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
